// File: rtl/reset_sequencer.sv
// Multi-domain reset generator: filters areset / ext_rst_n / soft_req, holds every
// domain in reset for 2^HOLD_BITS cycles, then releases the domains in ascending order.
module reset_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int SYNC_STAGES   = 4,
    parameter int HOLD_BITS     = 8,
    parameter int STEP_CYCLES   = 16,
    parameter int FILTER_CYCLES = 8
) (
    input  logic                   clock,
    input  logic                   areset,
    input  logic                   ext_rst_n,
    input  logic                   soft_req,
    output logic [NUM_DOMAINS-1:0] reset,
    output logic                   all_released,
    output logic                   busy,
    output logic [1:0]             cause
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_ARESET = 2'b01,
        CAUSE_EXT    = 2'b10,
        CAUSE_SOFT   = 2'b11
    } cause_e;

    localparam int HOLD_W = HOLD_BITS + 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int FILT_W = $clog2(FILTER_CYCLES + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = {1'b0, {HOLD_BITS{1'b1}}};
    localparam logic [HOLD_W-1:0] HOLD_MAX  = {1'b1, {HOLD_BITS{1'b0}}};
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_MAX  = FILT_W'(FILTER_CYCLES);

    logic [SYNC_STAGES-1:0] arst_sync_q, arst_sync_d;
    logic [SYNC_STAGES-1:0] ext_sync_q,  ext_sync_d;
    logic [FILT_W-1:0]      filt_q,      filt_d;
    state_e                 state_q,     state_d;
    logic [HOLD_W-1:0]      hold_q,      hold_d;
    logic [STEP_W-1:0]      step_q,      step_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [NUM_DOMAINS-1:0] reset_q,     reset_d;
    logic                   all_q,       all_d;
    logic                   busy_q,      busy_d;
    cause_e                 cause_q,     cause_d;

    logic in_arst;
    logic ext_low;
    logic ext_fire;

    always_comb begin
        // NOTE: every variable gets a default first so no branch can infer a latch.
        arst_sync_d = {arst_sync_q[SYNC_STAGES-2:0], 1'b0};
        ext_sync_d  = {ext_sync_q[SYNC_STAGES-2:0], ext_rst_n};
        in_arst     = arst_sync_q[SYNC_STAGES-1];
        ext_low     = ~ext_sync_q[SYNC_STAGES-1];

        // Saturating at FILTER_CYCLES makes the event fire once per low period.
        filt_d   = filt_q;
        ext_fire = ext_low && (filt_q == FILT_LAST);
        if (!ext_low) begin
            filt_d = '0;
        end else if (filt_q != FILT_MAX) begin
            filt_d = filt_q + 1'b1;
        end

        state_d = state_q;
        hold_d  = hold_q;
        step_d  = step_q;
        idx_d   = idx_q;
        reset_d = reset_q;
        cause_d = cause_q;

        case (state_q)
            ST_ASSERT: begin
                reset_d = '1;
                if (ext_fire) begin
                    hold_d  = '0;
                    cause_d = CAUSE_EXT;
                end else if (!in_arst) begin
                    // The 2^HOLD_BITS-th counted edge already releases domain 0.
                    if (hold_q == HOLD_LAST) begin
                        reset_d = {NUM_DOMAINS{1'b1}} << 1;
                        step_d  = '0;
                        idx_d   = IDX_W'(1);
                        state_d = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
                    end
                    if (hold_q != HOLD_MAX) begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_RELEASE, ST_RUN: begin
                if (ext_fire || soft_req) begin
                    state_d = ST_ASSERT;
                    hold_d  = '0;
                    step_d  = '0;
                    idx_d   = '0;
                    reset_d = '1;
                    cause_d = ext_fire ? CAUSE_EXT : CAUSE_SOFT;
                end else if (state_q == ST_RELEASE) begin
                    if (step_q == STEP_LAST) begin
                        step_d  = '0;
                        reset_d = reset_q & ~(NUM_DOMAINS'(1) << idx_q);
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ASSERT;
        endcase

        all_d  = (reset_d == '0);
        busy_d = (state_d != ST_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            arst_sync_q <= '1;
            ext_sync_q  <= '1;
            filt_q      <= '0;
            state_q     <= ST_ASSERT;
            hold_q      <= '0;
            step_q      <= '0;
            idx_q       <= '0;
            reset_q     <= '1;
            all_q       <= 1'b0;
            busy_q      <= 1'b1;
            cause_q     <= CAUSE_ARESET;
        end else begin
            arst_sync_q <= arst_sync_d;
            ext_sync_q  <= ext_sync_d;
            filt_q      <= filt_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            step_q      <= step_d;
            idx_q       <= idx_d;
            reset_q     <= reset_d;
            all_q       <= all_d;
            busy_q      <= busy_d;
            cause_q     <= cause_d;
        end
    end

    assign reset        = reset_q;
    assign all_released = all_q;
    assign busy         = busy_q;
    assign cause        = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: default build plus two small-parameter builds
// sharing the same stimulus; expectations are queued per cycle and compared at negedge.
module tb_reset_sequencer;

    localparam int SYNC = 4;
    localparam int FILT = 8;

    localparam int S_RST   = 0;
    localparam int S_ALL   = 1;
    localparam int S_BUSY  = 2;
    localparam int S_CAUSE = 3;
    localparam int S_ORST  = 4;
    localparam int S_OALL  = 5;
    localparam int S_OBUSY = 6;
    localparam int S_WRST  = 7;
    localparam int S_WALL  = 8;
    localparam int S_WBUSY = 9;
    localparam int S_WCAUSE = 10;

    logic        clock = 1'b0;
    logic        areset;
    logic        ext_rst_n;
    logic        soft_req;

    logic [3:0]  reset;
    logic        all_released, busy;
    logic [1:0]  cause;
    logic [0:0]  one_reset;
    logic        one_all, one_busy;
    logic [1:0]  one_cause;
    logic [15:0] wide_reset;
    logic        wide_all, wide_busy;
    logic [1:0]  wide_cause;

    reset_sequencer u_dut (
        .clock(clock), .areset(areset), .ext_rst_n(ext_rst_n), .soft_req(soft_req),
        .reset(reset), .all_released(all_released), .busy(busy), .cause(cause)
    );

    reset_sequencer #(.NUM_DOMAINS(1), .STEP_CYCLES(1), .HOLD_BITS(2)) u_one (
        .clock(clock), .areset(areset), .ext_rst_n(ext_rst_n), .soft_req(soft_req),
        .reset(one_reset), .all_released(one_all), .busy(one_busy), .cause(one_cause)
    );

    reset_sequencer #(.NUM_DOMAINS(16), .STEP_CYCLES(1), .HOLD_BITS(2)) u_wide (
        .clock(clock), .areset(areset), .ext_rst_n(ext_rst_n), .soft_req(soft_req),
        .reset(wide_reset), .all_released(wide_all), .busy(wide_busy), .cause(wide_cause)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RST:    return 32'(reset);
            S_ALL:    return 32'(all_released);
            S_BUSY:   return 32'(busy);
            S_CAUSE:  return 32'(cause);
            S_ORST:   return 32'(one_reset);
            S_OALL:   return 32'(one_all);
            S_OBUSY:  return 32'(one_busy);
            S_WRST:   return 32'(wide_reset);
            S_WALL:   return 32'(wide_all);
            S_WBUSY:  return 32'(wide_busy);
            S_WCAUSE: return 32'(one_cause == 2'b01 ? wide_cause : 2'b00);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_at(input int c, input int sel, input logic [31:0] v, input string tag);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    // Expected default-build trajectory from a start edge t0 (areset T0 or event edge).
    task automatic push_seq(input int t0, input logic [1:0] c, input int upto);
        int         offs[9] = '{0, 255, 256, 271, 272, 287, 288, 303, 304};
        logic [3:0] rv[9]   = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0};
        for (int i = 0; i < 9; i++) begin
            if (offs[i] <= upto) expect_at(t0 + offs[i], S_RST, 32'(rv[i]), "reset");
        end
        expect_at(t0, S_CAUSE, 32'(c), "cause_start");
        expect_at(t0, S_BUSY, 32'd1, "busy_start");
        expect_at(t0, S_ALL, 32'd0, "all_start");
        if (upto >= 304) begin
            expect_at(t0 + 303, S_ALL, 32'd0, "all_before_last");
            expect_at(t0 + 303, S_BUSY, 32'd1, "busy_before_last");
            expect_at(t0 + 304, S_ALL, 32'd1, "all_last");
            expect_at(t0 + 304, S_BUSY, 32'd0, "busy_last");
            expect_at(t0 + 304, S_CAUSE, 32'(c), "cause_last");
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    always @(negedge clock) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, observe(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        int t0, c, e, e1, e2, s, g;
        areset    = 1'b1;
        ext_rst_n = 1'b1;
        soft_req  = 1'b0;

        // Asynchronous reset state, before any clock edge.
        #1;
        check("por_reset", 32'(reset), 32'hF);
        check("por_all", 32'(all_released), 32'd0);
        check("por_busy", 32'(busy), 32'd1);
        check("por_cause", 32'(cause), 32'd1);

        // Power-up.
        wait_until(10);
        areset = 1'b0;
        t0 = 10 + SYNC;
        push_seq(t0, 2'b01, 304);
        expect_at(t0 + 3, S_ORST, 32'd1, "one_reset_hold");
        expect_at(t0 + 3, S_OALL, 32'd0, "one_all_hold");
        expect_at(t0 + 4, S_ORST, 32'd0, "one_reset_rel");
        expect_at(t0 + 4, S_OALL, 32'd1, "one_all_rel");
        expect_at(t0 + 4, S_OBUSY, 32'd0, "one_busy_rel");
        expect_at(t0 + 3, S_WRST, 32'hFFFF, "wide_hold");
        expect_at(t0 + 4, S_WRST, 32'hFFFE, "wide_bit0");
        expect_at(t0 + 10, S_WRST, 32'hFF80, "wide_bit6");
        expect_at(t0 + 18, S_WRST, 32'h8000, "wide_bit14");
        expect_at(t0 + 18, S_WALL, 32'd0, "wide_all_early");
        expect_at(t0 + 19, S_WRST, 32'h0000, "wide_bit15");
        expect_at(t0 + 19, S_WALL, 32'd1, "wide_all");
        expect_at(t0 + 19, S_WBUSY, 32'd0, "wide_busy");
        expect_at(t0 + 19, S_WCAUSE, 32'd1, "wide_cause");
        wait_until(t0 + 310);

        // areset from RUN, then a second pulse in the middle of the release.
        #1 areset = 1'b1;
        #1;
        check("arst_run_reset", 32'(reset), 32'hF);
        check("arst_run_busy", 32'(busy), 32'd1);
        s = cyc;
        wait_until(s + 3);
        areset = 1'b0;
        t0 = s + 3 + SYNC;
        push_seq(t0, 2'b01, 280);
        wait_until(t0 + 280);
        #1 areset = 1'b1;
        #1;
        check("arst_mid_reset", 32'(reset), 32'hF);
        check("arst_mid_all", 32'(all_released), 32'd0);
        check("arst_mid_busy", 32'(busy), 32'd1);
        check("arst_mid_cause", 32'(cause), 32'd1);
        wait_until(t0 + 282);
        areset = 1'b0;
        t0 = t0 + 282 + SYNC;
        push_seq(t0, 2'b01, 304);
        wait_until(t0 + 310);

        // Glitches of 3 and 7 cycles must be filtered out.
        g = cyc;
        ext_rst_n = 1'b0;
        wait_until(g + 3);
        ext_rst_n = 1'b1;
        expect_at(g + 14, S_RST, 32'h0, "glitch3_reset");
        expect_at(g + 14, S_CAUSE, 32'd1, "glitch3_cause");
        wait_until(g + 20);
        g = cyc;
        ext_rst_n = 1'b0;
        wait_until(g + 7);
        ext_rst_n = 1'b1;
        expect_at(g + 18, S_RST, 32'h0, "glitch7_reset");
        expect_at(g + 18, S_BUSY, 32'd0, "glitch7_busy");
        wait_until(g + 25);

        // Long external low: one event only, full release while still low.
        c = cyc;
        ext_rst_n = 1'b0;
        e = c + SYNC + FILT;
        expect_at(e - 1, S_RST, 32'h0, "ext_before");
        expect_at(e - 1, S_CAUSE, 32'd1, "ext_cause_before");
        push_seq(e, 2'b10, 304);
        wait_until(c + 500);
        ext_rst_n = 1'b1;
        expect_at(c + 510, S_RST, 32'h0, "ext_no_refire");
        expect_at(c + 510, S_ALL, 32'd1, "ext_no_refire_all");
        wait_until(c + 515);

        // Soft request in RUN; a second one during ASSERT is ignored.
        s = cyc;
        soft_req = 1'b1;
        e = s + 1;
        push_seq(e, 2'b11, 304);
        wait_until(e);
        soft_req = 1'b0;
        wait_until(e + 100);
        soft_req = 1'b1;
        wait_until(e + 101);
        soft_req = 1'b0;
        expect_at(e + 102, S_CAUSE, 32'd3, "soft_in_assert_cause");
        wait_until(e + 310);

        // Soft request and filtered external event on the same edge.
        c = cyc;
        ext_rst_n = 1'b0;
        e = c + SYNC + FILT;
        push_seq(e, 2'b10, 304);
        wait_until(e - 1);
        soft_req = 1'b1;
        wait_until(e);
        soft_req = 1'b0;
        wait_until(e + 5);
        ext_rst_n = 1'b1;
        wait_until(e + 310);

        // External event during ASSERT restarts the hold and overrides the cause.
        s = cyc;
        soft_req = 1'b1;
        e1 = s + 1;
        c = e1 + 20;
        e2 = c + SYNC + FILT;
        expect_at(e1, S_CAUSE, 32'd3, "soft_then_ext_c1");
        expect_at(e2 - 1, S_CAUSE, 32'd3, "soft_then_ext_c2");
        expect_at(e1 + 256, S_RST, 32'hF, "hold_restarted");
        push_seq(e2, 2'b10, 304);
        wait_until(e1);
        soft_req = 1'b0;
        wait_until(c);
        ext_rst_n = 1'b0;
        wait_until(e2 + 5);
        ext_rst_n = 1'b1;
        wait_until(e2 + 310);

        check("sb_pending", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
